// File: rtl/io_switch_port.sv
// io_switch_port: two slide switches -> 2-flop synchroniser -> per-bit debounce,
// exposed as clean levels to DMemory_IO and as two memory-mapped read registers
// (levels at SW_BASE, clear-on-read change flags at SW_BASE+1).
module io_switch_port #(
    parameter logic [15:0] SW_BASE  = 16'hFFF0,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  sw_raw,
    input  logic        rd_en,
    input  logic [15:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic        io_sw0,
    output logic        io_sw1,
    output logic [1:0]  sw_changed
);

    // Counter value at which a persisting new level is committed; the counter
    // never goes past it, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      FLAG_ADDR = SW_BASE + 16'd1;

    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       deb;
    logic [1:0]       flag;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       commit;
    logic             hit_level;
    logic             hit_flag;

    // Next counter value for one bit: restart on agreement or commit, else count.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic             same,
        input logic             at_last,
        input logic [CNT_W-1:0] cur
    );
        if (same || at_last)
            cnt_next = '0;
        else
            cnt_next = cur + CNT_ONE;
    endfunction

    // Read decode and commit detection; read data is the pre-edge register state.
    always_comb begin
        hit_level = rd_en && (rd_addr == SW_BASE);
        hit_flag  = rd_en && (rd_addr == FLAG_ADDR);
        rd_hit    = hit_level || hit_flag;
        rd_data   = '0;
        if (hit_level)
            rd_data = {14'b0, deb};
        else if (hit_flag)
            rd_data = {14'b0, flag};
        for (int i = 0; i < 2; i++)
            commit[i] = (sync_p1[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Per-bit debounce: a differing level must persist DEBOUNCE cycles to commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= cnt_next(sync_p1[i] == deb[i], commit[i], cnt[i]);
                if (commit[i])
                    deb[i] <= sync_p1[i];
            end
        end
    end

    // Sticky change flags; a commit on the same edge as a clearing read wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            flag <= '0;
        else
            flag <= commit | (flag & {2{~hit_flag}});
    end

    assign io_sw0     = deb[0];
    assign io_sw1     = deb[1];
    assign sw_changed = flag;

endmodule

// File: tb/tb_io_switch_port.sv
// Directed bench for io_switch_port with DEBOUNCE=4.
module tb_io_switch_port;

    logic        clock;
    logic        reset;
    logic [1:0]  sw_raw;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        io_sw0;
    logic        io_sw1;
    logic [1:0]  sw_changed;

    int total = 0;
    int bad   = 0;

    io_switch_port #(
        .SW_BASE (16'hFFF0),
        .DEBOUNCE(4),
        .CNT_W   (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .io_sw0    (io_sw0),
        .io_sw1    (io_sw1),
        .sw_changed(sw_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-edge read of the flag register to clear it.
    task automatic clear_flags();
        rd_en   = 1'b1;
        rd_addr = 16'hFFF1;
        steps(1);
        rd_en   = 1'b0;
        rd_addr = 16'h0000;
    endtask

    initial begin
        reset   = 1'b1;
        sw_raw  = 2'b11;
        rd_en   = 1'b0;
        rd_addr = 16'h0000;

        // Reset held with switches high
        steps(2);
        check("rst_sw0", {15'b0, io_sw0}, 16'h0);
        check("rst_sw1", {15'b0, io_sw1}, 16'h0);
        check("rst_chg", {14'b0, sw_changed}, 16'h0);
        check("rst_rdata", rd_data, 16'h0);
        check("rst_hit", {15'b0, rd_hit}, 16'h0);

        // Release: edge k is the next edge, commit at edge k+5 (6th edge)
        reset = 1'b0;
        steps(5);
        check("rel_sw0_early", {15'b0, io_sw0}, 16'h0);
        steps(1);
        check("rel_sw0", {15'b0, io_sw0}, 16'h1);
        check("rel_sw1", {15'b0, io_sw1}, 16'h1);
        check("rel_chg", {14'b0, sw_changed}, 16'h3);
        rd_en = 1'b1;
        rd_addr = 16'hFFF1;
        #1;
        check("rel_rd_flags", rd_data, 16'h0003);
        check("rel_rd_hit", {15'b0, rd_hit}, 16'h1);
        steps(1);
        rd_en = 1'b0;
        rd_addr = 16'h0000;
        check("rel_cleared", {14'b0, sw_changed}, 16'h0);

        // Clean step on switch 0
        sw_raw = 2'b00;
        steps(6);
        clear_flags();
        sw_raw = 2'b01;
        steps(5);
        check("step_sw0_early", {15'b0, io_sw0}, 16'h0);
        steps(1);
        check("step_sw0", {15'b0, io_sw0}, 16'h1);
        check("step_sw1", {15'b0, io_sw1}, 16'h0);
        check("step_chg", {14'b0, sw_changed}, 16'h1);

        // Glitch on switch 1: three cycles high never commits
        clear_flags();
        sw_raw = 2'b11;
        steps(3);
        sw_raw = 2'b01;
        steps(3);
        check("glitch_cnt1", dut.cnt[1], 16'h0);
        steps(6);
        check("glitch_sw1", {15'b0, io_sw1}, 16'h0);
        check("glitch_chg", {14'b0, sw_changed}, 16'h0);
        check("glitch_sw0", {15'b0, io_sw0}, 16'h1);

        // Bounce on switch 0: 1,0,1,0,1 then hold
        sw_raw = 2'b00;
        steps(6);
        clear_flags();
        sw_raw = 2'b01; steps(1);
        sw_raw = 2'b00; steps(1);
        sw_raw = 2'b01; steps(1);
        sw_raw = 2'b00; steps(1);
        sw_raw = 2'b01;
        steps(5);
        check("bounce_early", {15'b0, io_sw0}, 16'h0);
        steps(1);
        check("bounce_sw0", {15'b0, io_sw0}, 16'h1);
        check("bounce_chg", {14'b0, sw_changed}, 16'h1);

        // MMIO reads with io_sw={1,0}, flags=2'b10
        clear_flags();
        sw_raw = 2'b00;
        steps(6);
        clear_flags();
        sw_raw = 2'b10;
        steps(6);
        rd_en = 1'b1;
        rd_addr = 16'hFFF0;
        #1;
        check("mm_lvl_data", rd_data, 16'h0002);
        check("mm_lvl_hit", {15'b0, rd_hit}, 16'h1);
        steps(1);
        check("mm_lvl_noclr", {14'b0, sw_changed}, 16'h2);
        rd_addr = 16'hFFF1;
        #1;
        check("mm_flag_data", rd_data, 16'h0002);
        check("mm_flag_hit", {15'b0, rd_hit}, 16'h1);
        steps(1);
        check("mm_flag_clr", {14'b0, sw_changed}, 16'h0);
        check("mm_flag_after", rd_data, 16'h0000);
        rd_addr = 16'h0004;
        #1;
        check("mm_miss_data", rd_data, 16'h0000);
        check("mm_miss_hit", {15'b0, rd_hit}, 16'h0);
        rd_en = 1'b0;
        rd_addr = 16'hFFF0;
        #1;
        check("mm_noen_data", rd_data, 16'h0000);
        check("mm_noen_hit", {15'b0, rd_hit}, 16'h0);
        rd_addr = 16'h0000;

        // Clear/commit collision on switch 0, flag 1 set beforehand
        sw_raw = 2'b00;
        steps(6);
        sw_raw = 2'b01;
        steps(5);
        rd_en = 1'b1;
        rd_addr = 16'hFFF1;
        #1;
        check("col_rd_old", rd_data, 16'h0002);
        steps(1);
        check("col_chg", {14'b0, sw_changed}, 16'h1);
        check("col_sw0", {15'b0, io_sw0}, 16'h1);
        steps(1);
        check("col_held_clr", {14'b0, sw_changed}, 16'h0);
        rd_en = 1'b0;
        rd_addr = 16'h0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_switch_port.md
Name: io_switch_port

Overview:
- Input-direction counterpart to the 7-segment display output of the data-memory IO device.
- Takes the two raw slide switches and passes each through a 2-flop synchroniser and a per-bit debounce counter.
- Presents clean levels on io_sw0/io_sw1 to DMemory_IO and also responds to processor memory-mapped reads.
- Memory-mapped reads return the switch levels and clear-on-read change flags. Sits between the board pins and the data-memory/IO decode.

Parameters:
- SW_BASE, 16'hFFF0, word address of the level register; the change-flag register is at SW_BASE+1.
- DEBOUNCE, 4, consecutive cycles a new synchronised value must persist before it is committed. Legal range is 1..65535. Board builds use a large value; simulation uses 4.
- CNT_W, 16, width of each debounce counter. Must hold DEBOUNCE-1.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- sw_raw, input, 2, raw switch pins (bit0 = switch 0, bit1 = switch 1); asynchronous to clock.
- rd_en, input, 1, processor data-memory read enable (dmemread).
- rd_addr, input, 16, processor data-memory address (dmemaddr).
- rd_data, output, 16, read data for this block's addresses.
- rd_hit, output, 1, high when this block claims the current read.
- io_sw0, output, 1, debounced switch 0 level.
- io_sw1, output, 1, debounced switch 1 level.
- sw_changed, output, 2, sticky change flags (debug/monitor view of the flag register).

Behaviour:
- Reset (async, reset=1): sync stages, debounced levels, counters and flags all go to 0. io_sw0=io_sw1=0, sw_changed=0. rd_data and rd_hit are combinational, so they read 0 while rd_en=0.
- Reset deasserted mid-bounce: debouncing restarts from the zero state. A raw input already high commits after the full latency.
- Synchroniser, per bit: s1<=sw_raw, then s2<=s1.
- Debounce, per bit i, each rising edge:
  - if s2[i]==deb[i]: cnt[i]<=0.
  - else if cnt[i]==DEBOUNCE-1: deb[i]<=s2[i], cnt[i]<=0, flag[i]<=1.
  - else: cnt[i]<=cnt[i]+1.
- Latency: raw change set up before edge k appears on io_sw at edge k+1+DEBOUNCE (edge k+5 for DEBOUNCE=4; edge k+2 for DEBOUNCE=1).
- Glitches: a glitch whose synchronised length is shorter than DEBOUNCE cycles never commits and its counter returns to 0. Counters cannot wrap, because they saturate at the commit point.
- io_sw0=deb[0], io_sw1=deb[1], sw_changed=flag.
- Read decode (combinational):
  - rd_hit = rd_en & (rd_addr==SW_BASE | rd_addr==SW_BASE+1).
  - rd_addr==SW_BASE: rd_data = {14'b0, deb[1], deb[0]}.
  - rd_addr==SW_BASE+1: rd_data = {14'b0, flag[1], flag[0]}.
  - Otherwise rd_data = 16'h0000 and rd_hit=0.
- Clear-on-read: on a rising edge with rd_en=1 and rd_addr==SW_BASE+1, flag<=0.
  - Same-edge commit and clear: the commit wins, so that flag bit ends at 1. The value read that cycle is the pre-edge flags.
  - A read held for multiple cycles clears on every edge.
- Reading SW_BASE has no side effects.
- No write path: processor writes to these addresses are ignored by this block.
- Both bits are fully independent and may commit on the same edge.

Test Plan:
- Reset: hold reset=1 with sw_raw=2'b11 -> io_sw0=io_sw1=0 and sw_changed=0 during reset. After release at edge k, io_sw0=io_sw1=1 at edge k+5 and sw_changed=2'b11.
- Clean step, DEBOUNCE=4: sw_raw 00->01 before edge 10 -> io_sw0 rises exactly at edge 15, io_sw1 stays 0, sw_changed=2'b01. io_sw0 is still 0 after edge 14.
- Glitch rejection: sw_raw[1] high for 3 cycles then low -> io_sw1 never changes, sw_changed[1]=0, cnt[1] back to 0.
- Bounce: sw_raw[0] toggles 1,0,1,0,1 with one cycle each step, then holds 1 -> commit occurs 5 edges after the final rising step, not before.
- MMIO read: io_sw={1,0} and flags=2'b10. rd_en=1, rd_addr=16'hFFF0 -> rd_data=16'h0002 and rd_hit=1. rd_addr=16'hFFF1 -> rd_data=16'h0002, then flags=0 after the edge. rd_addr=16'h0004 -> rd_data=0, rd_hit=0.
- Clear/commit collision: read 16'hFFF1 on the same edge that switch 0 commits -> that cycle rd_data shows the old flag. After the edge, sw_changed[0]=1 and the other bit is cleared.
